// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: arbitrates traps, jump redirects, EX busy and ID
// hazards into stall/flush buses for the PC, IF/ID and ID/EX registers,
// handles the redirect handshake with the IFU and watches for stall deadlock.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; stall/flush taken from the live requests
// REDIRECT | redirect presented to the IFU, waiting for ifu_ready_i
// DRAIN    | redirect accepted; flushing wrong-path fetches still in flight

`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 2
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned STALL_TIMEOUT = 1023,
  parameter int unsigned CNT_W         = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trap_req_i,
  input  logic [`INST_ADDR_WIDTH-1:0]   trap_addr_i,
  input  logic                          jump_req_i,
  input  logic [`INST_ADDR_WIDTH-1:0]   jump_addr_i,
  input  logic                          ex_busy_i,
  input  logic                          hazard_stall_i,
  input  logic                          ifu_ready_i,
  output logic [`CU_BUS_WIDTH-1:0]      stall_flag_pc_o,
  output logic [`CU_BUS_WIDTH-1:0]      stall_flag_if_id_o,
  output logic [`CU_BUS_WIDTH-1:0]      stall_flag_id_ex_o,
  output logic                          redirect_valid_o,
  output logic [`INST_ADDR_WIDTH-1:0]   redirect_addr_o,
  output logic                          busy_o,
  output logic                          stall_timeout_o
);

  localparam int unsigned DRAIN_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [`CU_BUS_WIDTH-1:0] BUS_NONE  = '0;
  localparam logic [`CU_BUS_WIDTH-1:0] BUS_STALL = `CU_BUS_WIDTH'(1) << `CU_STALL;
  localparam logic [`CU_BUS_WIDTH-1:0] BUS_FLUSH = `CU_BUS_WIDTH'(1) << `CU_FLUSH;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic                          valid_nxt;
  logic [`INST_ADDR_WIDTH-1:0]   addr_nxt;
  logic [DRAIN_W-1:0]            drain_cnt, drain_nxt;
  logic [CNT_W-1:0]              stall_cnt;
  logic                          any_stall;

  // Flag buses: combinational so a request is honoured in its own cycle.
  always_comb begin
    stall_flag_pc_o    = BUS_NONE;
    stall_flag_if_id_o = BUS_NONE;
    stall_flag_id_ex_o = BUS_NONE;
    unique case (state)
      ST_RUN: begin
        if (trap_req_i || jump_req_i) begin
          stall_flag_if_id_o = BUS_FLUSH;
          stall_flag_id_ex_o = BUS_FLUSH;
        end else if (ex_busy_i) begin
          stall_flag_pc_o    = BUS_STALL;
          stall_flag_if_id_o = BUS_STALL;
          stall_flag_id_ex_o = BUS_STALL;
        end else if (hazard_stall_i) begin
          // bubble: hold fetch/decode, squash what would enter EX
          stall_flag_pc_o    = BUS_STALL;
          stall_flag_if_id_o = BUS_STALL;
          stall_flag_id_ex_o = BUS_FLUSH;
        end
      end
      ST_REDIRECT: begin
        stall_flag_pc_o    = BUS_STALL;
        stall_flag_if_id_o = BUS_FLUSH;
        stall_flag_id_ex_o = BUS_FLUSH;
      end
      ST_DRAIN: begin
        stall_flag_if_id_o = BUS_FLUSH;
        stall_flag_id_ex_o = BUS_FLUSH;
      end
      default: begin
        stall_flag_pc_o    = BUS_NONE;
      end
    endcase
  end

  assign any_stall = stall_flag_pc_o[`CU_STALL] | stall_flag_if_id_o[`CU_STALL] |
                     stall_flag_id_ex_o[`CU_STALL];
  assign busy_o    = (state != ST_RUN);

  // Next-state, redirect request and drain counter; a trap always wins.
  always_comb begin
    state_nxt = state;
    valid_nxt = redirect_valid_o;
    addr_nxt  = redirect_addr_o;
    drain_nxt = drain_cnt;
    unique case (state)
      ST_RUN: begin
        if (trap_req_i || jump_req_i) begin
          state_nxt = ST_REDIRECT;
          valid_nxt = 1'b1;
          addr_nxt  = trap_req_i ? trap_addr_i : jump_addr_i;
        end
      end
      ST_REDIRECT: begin
        if (trap_req_i) begin
          // an accept in this same cycle consumes the old redirect; the
          // trap target is presented fresh next cycle
          valid_nxt = 1'b1;
          addr_nxt  = trap_addr_i;
        end else if (ifu_ready_i) begin
          state_nxt = ST_DRAIN;
          valid_nxt = 1'b0;
          drain_nxt = DRAIN_W'(FLUSH_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (trap_req_i) begin
          state_nxt = ST_REDIRECT;
          valid_nxt = 1'b1;
          addr_nxt  = trap_addr_i;
          drain_nxt = '0;
        end else if (drain_cnt <= DRAIN_W'(1)) begin
          state_nxt = ST_RUN;
          drain_nxt = '0;
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
        valid_nxt = 1'b0;
        drain_nxt = '0;
      end
    endcase
  end

  // State and redirect registers; reset kills any pending redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_RUN;
      redirect_valid_o <= 1'b0;
      redirect_addr_o  <= '0;
      drain_cnt        <= '0;
    end else begin
      state            <= state_nxt;
      redirect_valid_o <= valid_nxt;
      redirect_addr_o  <= addr_nxt;
      drain_cnt        <= drain_nxt;
    end
  end

  // Deadlock watchdog: consecutive RUN stall cycles, saturating, sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt       <= '0;
      stall_timeout_o <= 1'b0;
    end else begin
      if (state == ST_RUN) begin
        if (any_stall) begin
          if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
          stall_cnt <= '0;
        end
      end
      if ((STALL_TIMEOUT != 0) && (stall_cnt == CNT_W'(STALL_TIMEOUT)))
        stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 2
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module tb_pipe_hazard_ctrl;

  localparam logic [`CU_BUS_WIDTH-1:0] N = '0;
  localparam logic [`CU_BUS_WIDTH-1:0] S = `CU_BUS_WIDTH'(1) << `CU_STALL;
  localparam logic [`CU_BUS_WIDTH-1:0] F = `CU_BUS_WIDTH'(1) << `CU_FLUSH;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        trap_req, jump_req, ex_busy, hazard_stall, ifu_ready;
  logic [`INST_ADDR_WIDTH-1:0] trap_addr, jump_addr;
  logic [`CU_BUS_WIDTH-1:0]    flag_pc, flag_if_id, flag_id_ex;
  logic                        redirect_valid, busy, stall_timeout;
  logic [`INST_ADDR_WIDTH-1:0] redirect_addr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .STALL_TIMEOUT(8),
    .CNT_W        (10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .trap_req_i        (trap_req),
    .trap_addr_i       (trap_addr),
    .jump_req_i        (jump_req),
    .jump_addr_i       (jump_addr),
    .ex_busy_i         (ex_busy),
    .hazard_stall_i    (hazard_stall),
    .ifu_ready_i       (ifu_ready),
    .stall_flag_pc_o   (flag_pc),
    .stall_flag_if_id_o(flag_if_id),
    .stall_flag_id_ex_o(flag_id_ex),
    .redirect_valid_o  (redirect_valid),
    .redirect_addr_o   (redirect_addr),
    .busy_o            (busy),
    .stall_timeout_o   (stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [`CU_BUS_WIDTH-1:0] pc,
                           input logic [`CU_BUS_WIDTH-1:0] ifid,
                           input logic [`CU_BUS_WIDTH-1:0] idex);
    chk({tag, "_pc"},    32'(flag_pc),    32'(pc));
    chk({tag, "_if_id"}, 32'(flag_if_id), 32'(ifid));
    chk({tag, "_id_ex"}, 32'(flag_id_ex), 32'(idex));
  endtask

  // advance to the next cycle, apply inputs, let combinational outputs settle
  task automatic go(input logic tr, input logic [31:0] ta, input logic jr, input logic [31:0] ja,
                    input logic eb, input logic hz, input logic rdy);
    @(negedge clk);
    trap_req = tr; trap_addr = ta; jump_req = jr; jump_addr = ja;
    ex_busy = eb; hazard_stall = hz; ifu_ready = rdy;
    #1;
  endtask

  initial begin
    trap_req = 0; trap_addr = '0; jump_req = 0; jump_addr = '0;
    ex_busy = 0; hazard_stall = 0; ifu_ready = 0;
    #1;
    chk_flags("reset", N, N, N);
    chk("reset_rv", 32'(redirect_valid), 0);
    chk("reset_ra", redirect_addr, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_to", 32'(stall_timeout), 0);

    @(negedge clk); rst = 0;
    go(0, 0, 0, 0, 0, 0, 0);
    chk_flags("idle", N, N, N);

    // load-use bubble for one cycle
    go(0, 0, 0, 0, 0, 1, 0);
    chk_flags("hazard", S, S, F);
    go(0, 0, 0, 0, 0, 0, 0);
    chk_flags("hazard_after", N, N, N);

    // jump redirect, IFU busy 3 cycles then accepts
    go(0, 0, 1, 32'h8000_0100, 0, 0, 0);
    chk_flags("jump_req", N, F, F);
    chk("jump_req_rv", 32'(redirect_valid), 0);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0, 0, 0, 0, 0);
      chk("redir_wait_rv", 32'(redirect_valid), 1);
      chk("redir_wait_ra", redirect_addr, 32'h8000_0100);
      chk_flags("redir_wait", S, F, F);
    end
    go(0, 0, 0, 0, 0, 0, 1);
    chk("redir_acc_rv", 32'(redirect_valid), 1);
    chk("redir_acc_ra", redirect_addr, 32'h8000_0100);
    chk("redir_acc_busy", 32'(busy), 1);
    // busy/hazard ignored while draining
    for (int i = 0; i < 2; i++) begin
      go(0, 0, 0, 0, 1, 1, 0);
      chk("drain_rv", 32'(redirect_valid), 0);
      chk("drain_busy", 32'(busy), 1);
      chk_flags("drain", N, F, F);
    end
    go(0, 0, 0, 0, 0, 0, 0);
    chk("run_busy", 32'(busy), 0);
    chk_flags("run", N, N, N);

    // trap beats jump in the same cycle
    go(1, 32'h8000_0004, 1, 32'h8000_0100, 0, 0, 0);
    chk_flags("trap_jump", N, F, F);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("trap_jump_rv", 32'(redirect_valid), 1);
    chk("trap_jump_ra", redirect_addr, 32'h8000_0004);

    // trap arriving with the accept of the previous redirect
    go(1, 32'h8000_0200, 0, 0, 0, 0, 1);
    chk("trap_acc_ra_old", redirect_addr, 32'h8000_0004);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("trap_acc_rv", 32'(redirect_valid), 1);
    chk("trap_acc_ra", redirect_addr, 32'h8000_0200);
    chk_flags("trap_acc", S, F, F);
    go(0, 0, 0, 0, 0, 0, 1);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("trap_drain1_busy", 32'(busy), 1);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("trap_drain2_busy", 32'(busy), 1);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("trap_run_busy", 32'(busy), 0);

    // EX busy together with a hazard: pure stall, no flush anywhere
    go(0, 0, 0, 0, 1, 1, 0);
    chk_flags("busy_hazard", S, S, S);
    go(0, 0, 0, 0, 0, 0, 0);
    chk_flags("busy_hazard_after", N, N, N);

    // watchdog: 8 consecutive stall cycles
    for (int i = 0; i < 8; i++) begin
      go(0, 0, 0, 0, 1, 0, 0);
      chk("wd_counting", 32'(stall_timeout), 0);
    end
    go(0, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("wd_set", 32'(stall_timeout), 1);
    go(0, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("wd_sticky", 32'(stall_timeout), 1);

    // async reset while a redirect is pending
    go(0, 0, 1, 32'h8000_0300, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_rv", 32'(redirect_valid), 1);
    #2 rst = 1;
    #1;
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_ra", redirect_addr, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(stall_timeout), 0);
    @(negedge clk); rst = 0;
    go(0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_rv", 32'(redirect_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk_flags("post_rst", N, N, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
